// File: rtl/alu_sequencer.sv
// Issue controller for the 64-bit combinational ALU: accepts micro-ops, reads operands from a local
// register file, drives the ALU from registers, writes the result back and pulses completion.
module alu_sequencer #(
  parameter int WIDTH = 64,
  parameter int NREGS = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_cmd,
  input  logic [6:0]       in_opm,
  input  logic [AW-1:0]    in_rd,
  input  logic [AW-1:0]    in_ra,
  input  logic [AW-1:0]    in_rb,
  input  logic             host_we,
  input  logic [AW-1:0]    host_addr,
  input  logic [WIDTH-1:0] host_wdata,
  output logic [WIDTH-1:0] host_rdata,
  output logic [4:0]       alu_cmd,
  output logic [6:0]       alu_opm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  output logic             res_valid,
  output logic             res_err,
  output logic [WIDTH-1:0] res_data,
  output logic [AW-1:0]    res_rd,
  output logic [15:0]      op_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_rf [NREGS];
  logic [4:0]       r_alu_cmd;
  logic [6:0]       r_alu_opm;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [WIDTH-1:0] r_res_data;
  logic [WIDTH-1:0] r_host_rdata;
  logic [AW-1:0]    r_rd;
  logic             r_err;
  logic [15:0]      r_op_count;
  logic             w_accept;
  logic             w_bad_cmd;
  logic             w_wb;
  logic             w_enter_done;

  assign w_accept     = (r_state == IDLE) && in_valid;
  assign w_bad_cmd    = (in_cmd >= 5'd30);
  assign w_wb         = (r_state == ISSUE) && (r_rd != '0);
  assign w_enter_done = (w_accept && w_bad_cmd) || (r_state == ISSUE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = w_bad_cmd ? DONE : ISSUE;
      end
      ISSUE: w_next = DONE;
      DONE: begin
        res_valid = 1'b1;
        w_next    = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // ALU port registers only move on a valid-command accept so the ALU flags never see a spurious change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_cmd    <= '0;
      r_alu_opm    <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_rd         <= '0;
      r_err        <= 1'b0;
      r_res_data   <= '0;
      r_op_count   <= '0;
      r_host_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_rd  <= in_rd;
        r_err <= w_bad_cmd;
        if (!w_bad_cmd) begin
          r_alu_cmd <= in_cmd;
          r_alu_opm <= in_opm;
          r_alu_a   <= r_rf[in_ra];
          r_alu_b   <= r_rf[in_rb];
        end
      end
      if (r_state == ISSUE) r_res_data <= alu_out;
      if (w_enter_done && (r_op_count != 16'hFFFF)) r_op_count <= r_op_count + 16'd1;
      r_host_rdata <= r_rf[host_addr];
    end
  end

  // Entry 0 is never written, so it reads zero; writeback takes priority over a host write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (w_wb && (r_rd == AW'(i)))               r_rf[i] <= alu_out;
        else if (host_we && (host_addr == AW'(i)))  r_rf[i] <= host_wdata;
      end
    end
  end

  assign alu_cmd    = r_alu_cmd;
  assign alu_opm    = r_alu_opm;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign res_err    = r_err && res_valid;
  assign res_data   = r_res_data;
  assign res_rd     = r_rd;
  assign op_count   = r_op_count;
  assign host_rdata = r_host_rdata;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small combinational ALU model on alu_out.
module tb_alu_sequencer;

  localparam int WIDTH = 64;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [4:0]       in_cmd = '0;
  logic [6:0]       in_opm = '0;
  logic [AW-1:0]    in_rd = '0, in_ra = '0, in_rb = '0;
  logic             host_we = 1'b0;
  logic [AW-1:0]    host_addr = '0;
  logic [WIDTH-1:0] host_wdata = '0;
  logic [WIDTH-1:0] host_rdata;
  logic [4:0]       alu_cmd;
  logic [6:0]       alu_opm;
  logic [WIDTH-1:0] alu_a, alu_b, alu_out;
  logic             res_valid, res_err;
  logic [WIDTH-1:0] res_data;
  logic [AW-1:0]    res_rd;
  logic [15:0]      op_count;

  int checks = 0;
  int errors = 0;
  int mCount = 0;

  typedef struct {
    logic [4:0]  cmd;
    logic [6:0]  opm;
    logic [2:0]  rd;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [4:0]  expCmd;
    logic [63:0] expA;
    logic [63:0] expB;
    logic [63:0] expData;
    logic        expErr;
    int          expLat;
    logic [63:0] expRdVal;
  } vec_t;

  vec_t vecs[5];
  vec_t addmVec;

  alu_sequencer #(.WIDTH(64), .NREGS(8), .AW(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_cmd(in_cmd), .in_opm(in_opm), .in_rd(in_rd), .in_ra(in_ra), .in_rb(in_rb),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .alu_cmd(alu_cmd), .alu_opm(alu_opm), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
    .res_valid(res_valid), .res_err(res_err), .res_data(res_data), .res_rd(res_rd),
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Stand-in ALU: 3 AND, 5 XOR, 18 ADDM (a + sign-extended opm), 19 ADD, 20 SUB, else OR.
  function automatic logic [63:0] aluModel(input logic [4:0] c, input logic [6:0] m,
                                           input logic [63:0] a, input logic [63:0] b);
    case (c)
      5'd3:    return a & b;
      5'd5:    return a ^ b;
      5'd18:   return a + {{57{m[6]}}, m};
      5'd19:   return a + b;
      5'd20:   return a - b;
      default: return a | b;
    endcase
  endfunction

  assign alu_out = aluModel(alu_cmd, alu_opm, alu_a, alu_b);

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic hostWrite(input logic [2:0] addr, input logic [63:0] data);
    @(negedge clk);
    host_we = 1'b1; host_addr = addr; host_wdata = data;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic hostRead(input logic [2:0] addr, output logic [63:0] data);
    @(negedge clk);
    host_addr = addr;
    @(negedge clk);
    data = host_rdata;
  endtask

  task automatic applyStimulus(input vec_t v);
    int lat;
    logic [63:0] rdv;
    @(negedge clk);
    in_valid = 1'b1; in_cmd = v.cmd; in_opm = v.opm; in_rd = v.rd; in_ra = v.ra; in_rb = v.rb;
    checkOutput("ready_before_accept", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0; in_cmd = 5'd29; in_opm = 7'h55; in_rd = ~v.rd; in_ra = ~v.ra; in_rb = ~v.rb;
    checkOutput("alu_cmd", 64'(alu_cmd), 64'(v.expCmd));
    checkOutput("alu_a", alu_a, v.expA);
    checkOutput("alu_b", alu_b, v.expB);
    lat = 1;
    while (res_valid !== 1'b1 && lat < 6) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("latency", 64'(lat), 64'(v.expLat));
    checkOutput("res_err", 64'(res_err), 64'(v.expErr));
    checkOutput("res_rd", 64'(res_rd), 64'(v.rd));
    if (!v.expErr) checkOutput("res_data", res_data, v.expData);
    @(negedge clk);
    checkOutput("res_valid_single_pulse", 64'(res_valid), 64'd0);
    mCount++;
    checkOutput("op_count", 64'(op_count), 64'(mCount));
    hostRead(v.rd, rdv);
    checkOutput("rd_readback", rdv, v.expRdVal);
  endtask

  initial begin
    logic [63:0] rdv;
    logic [4:0]  pCmd [3];
    logic [2:0]  pRd [3], pRa [3], pRb [3];
    logic [63:0] pExp [3];
    logic        rdy [9], rv [9];
    logic [63:0] rdat [9];
    int          idx;
    logic        sawValid;

    vecs[0] = '{5'd19, 7'd0, 3'd3, 3'd1, 3'd2, 5'd19, 64'd10, 64'hFFFF_FFFF_FFFF_FFF1,
                64'hFFFF_FFFF_FFFF_FFFB, 1'b0, 2, 64'hFFFF_FFFF_FFFF_FFFB};
    vecs[1] = '{5'd5, 7'd0, 3'd4, 3'd1, 3'd3, 5'd5, 64'd10, 64'hFFFF_FFFF_FFFF_FFFB,
                64'hFFFF_FFFF_FFFF_FFF1, 1'b0, 2, 64'hFFFF_FFFF_FFFF_FFF1};
    vecs[2] = '{5'd20, 7'd0, 3'd5, 3'd1, 3'd2, 5'd20, 64'd10, 64'hFFFF_FFFF_FFFF_FFF1,
                64'h19, 1'b0, 2, 64'h19};
    vecs[3] = '{5'd3, 7'd0, 3'd6, 3'd4, 3'd5, 5'd3, 64'hFFFF_FFFF_FFFF_FFF1, 64'h19,
                64'h11, 1'b0, 2, 64'h11};
    vecs[4] = '{5'd30, 7'd9, 3'd4, 3'd1, 3'd2, 5'd3, 64'hFFFF_FFFF_FFFF_FFF1, 64'h19,
                64'h0, 1'b1, 1, 64'hFFFF_FFFF_FFFF_FFF1};
    addmVec = '{5'd18, 7'b1111110, 3'd0, 3'd1, 3'd2, 5'd18, 64'd5, 64'hFFFF_FFFF_FFFF_FFF1,
                64'd3, 1'b0, 2, 64'd0};

    pCmd = '{5'd5, 5'd3, 5'd20};
    pRd  = '{3'd7, 3'd6, 3'd7};
    pRa  = '{3'd1, 3'd7, 3'd7};
    pRb  = '{3'd6, 3'd5, 3'd1};
    pExp = '{64'h1B, 64'h19, 64'h11};

    repeat (2) @(negedge clk);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_res_valid", 64'(res_valid), 64'd0);
    checkOutput("reset_op_count", 64'(op_count), 64'd0);
    checkOutput("reset_alu_a", alu_a, 64'd0);
    rst = 1'b0;

    hostWrite(3'd1, 64'd10);
    hostWrite(3'd2, 64'hFFFF_FFFF_FFFF_FFF1);

    for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);

    // Back-to-back ops with in_valid held high.
    @(negedge clk);
    idx = 0;
    in_valid = 1'b1; in_cmd = pCmd[0]; in_opm = '0; in_rd = pRd[0]; in_ra = pRa[0]; in_rb = pRb[0];
    for (int i = 0; i < 9; i++) begin
      rdy[i] = in_ready; rv[i] = res_valid; rdat[i] = res_data;
      @(negedge clk);
      if (rdy[i]) begin
        idx++;
        if (idx < 3) begin
          in_cmd = pCmd[idx]; in_rd = pRd[idx]; in_ra = pRa[idx]; in_rb = pRb[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    for (int i = 0; i < 9; i++) begin
      checkOutput($sformatf("pipe_ready_%0d", i), 64'(rdy[i]), 64'((i % 3) == 0 && i < 7));
      checkOutput($sformatf("pipe_res_valid_%0d", i), 64'(rv[i]), 64'((i % 3) == 2));
      if ((i % 3) == 2) checkOutput($sformatf("pipe_res_data_%0d", i), rdat[i], pExp[i / 3]);
    end
    mCount += 3;
    checkOutput("pipe_op_count", 64'(op_count), 64'(mCount));
    hostRead(3'd6, rdv);
    checkOutput("pipe_r6", rdv, 64'h19);
    hostRead(3'd7, rdv);
    checkOutput("pipe_r7", rdv, 64'h11);

    hostWrite(3'd1, 64'd5);
    applyStimulus(addmVec);

    // Host write and writeback to r5 on the same edge.
    hostWrite(3'd3, 64'h50);
    @(negedge clk);
    in_valid = 1'b1; in_cmd = 5'd5; in_rd = 3'd5; in_ra = 3'd1; in_rb = 3'd3;
    @(negedge clk);
    in_valid = 1'b0;
    host_we = 1'b1; host_addr = 3'd5; host_wdata = 64'hAA;
    @(negedge clk);
    host_we = 1'b0;
    checkOutput("collide_res_valid", 64'(res_valid), 64'd1);
    checkOutput("collide_res_data", res_data, 64'h55);
    mCount++;
    hostRead(3'd5, rdv);
    checkOutput("collide_r5", rdv, 64'h55);

    // Host write to the source register on the accept edge is not seen by that op.
    @(negedge clk);
    in_valid = 1'b1; in_cmd = 5'd19; in_rd = 3'd2; in_ra = 3'd1; in_rb = 3'd1;
    host_we = 1'b1; host_addr = 3'd1; host_wdata = 64'd100;
    @(negedge clk);
    in_valid = 1'b0; host_we = 1'b0;
    @(negedge clk);
    checkOutput("hazard_res_data", res_data, 64'd10);
    mCount++;
    hostRead(3'd1, rdv);
    checkOutput("hazard_r1", rdv, 64'd100);
    hostRead(3'd2, rdv);
    checkOutput("hazard_r2", rdv, 64'd10);

    hostWrite(3'd0, 64'h123);
    hostRead(3'd0, rdv);
    checkOutput("r0_host_write_ignored", rdv, 64'd0);
    repeat (3) @(negedge clk);
    checkOutput("idle_op_count", 64'(op_count), 64'(mCount));
    checkOutput("idle_in_ready", 64'(in_ready), 64'd1);

    // Reset while an op sits in ISSUE.
    @(negedge clk);
    in_valid = 1'b1; in_cmd = 5'd19; in_rd = 3'd3; in_ra = 3'd1; in_rb = 3'd2;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("rst_res_valid", 64'(res_valid), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_op_count", 64'(op_count), 64'd0);
    checkOutput("rst_alu_a", alu_a, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    sawValid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sawValid |= res_valid;
    end
    checkOutput("rst_no_res_valid", 64'(sawValid), 64'd0);
    checkOutput("rst_in_ready_after", 64'(in_ready), 64'd1);
    for (int r = 0; r < 8; r++) begin
      hostRead(3'(r), rdv);
      checkOutput($sformatf("rst_rf_%0d", r), rdv, 64'd0);
    end
    checkOutput("rst_op_count_after", 64'(op_count), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Issuing controller for the 64-bit combinational ALU (cmd[4:0], opm[6:0], a, b -> out).
- Accepts micro-ops over a valid/ready handshake and reads operands from a local register file.
- Drives the ALU input ports from registers, captures the ALU result and writes it back, then reports completion.
- The host preloads and reads back the register file through a side port.

Parameters:
WIDTH, 64, datapath width (must match ALU)
NREGS, 8, register file depth
AW, 3, register index width (log2 NREGS)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  micro-op valid
in_ready  out  1  sequencer can accept a micro-op
in_cmd  in  5  ALU command code
in_opm  in  7  ALU operation-mode field
in_rd  in  AW  destination register
in_ra  in  AW  source register for ALU a
in_rb  in  AW  source register for ALU b
host_we  in  1  host register write strobe
host_addr  in  AW  host write/read index
host_wdata  in  WIDTH  host write data
host_rdata  out  WIDTH  rf[host_addr], registered (1-cycle latency)
alu_cmd  out  5  to ALU cmd
alu_opm  out  7  to ALU opm
alu_a  out  WIDTH  to ALU a
alu_b  out  WIDTH  to ALU b
alu_out  in  WIDTH  from ALU out
res_valid  out  1  one-cycle completion pulse
res_err  out  1  qualifies res_valid; op rejected
res_data  out  WIDTH  captured result
res_rd  out  AW  destination of completed op
op_count  out  16  completed-op counter, saturating at 16'hFFFF

Behaviour:
- Reset (async assert, sync deassert):
  - FSM = IDLE; all rf entries = 0.
  - All outputs 0, except in_ready = 1 once the FSM is in IDLE.
  - Reset during any state aborts the op with no res_valid and no writeback.
- FSM states: IDLE, ISSUE, DONE.
  - IDLE:
    - in_ready = 1.
    - On in_valid && in_ready, latch cmd/opm/rd and rf[ra]/rf[rb] read before the edge.
    - A host write to ra/rb on the same edge is not seen by this op.
    - A valid cmd (0..29) goes to ISSUE. A cmd of 30 or 31 goes to DONE with res_err = 1 and the ALU port registers unchanged.
  - ISSUE:
    - in_ready = 0.
    - alu_cmd/opm/a/b registers carry the op for the full cycle.
    - At the end-of-cycle edge, capture alu_out into res_data and rf[rd] (rd = 0: write discarded, res_data still valid), then go to DONE.
  - DONE:
    - in_ready = 0; res_valid = 1 for exactly this cycle; op_count += 1 (also for errors).
    - Next state is IDLE.
- Latency and throughput:
  - Accept edge E0; result written at E1; res_valid high during cycle E1..E2.
  - Throughput is one op per 3 cycles.
- ALU port stability:
  - alu_* registers change only on a valid-cmd acceptance edge.
  - They hold their values through IDLE, because the ALU updates its internal flags whenever its inputs change.
  - Never drive an idle or default command.
- Register file:
  - rf[0] reads 0 always.
  - Host write and writeback to the same index on the same edge: writeback wins.
  - Host writes to rf[0] are ignored.
- host_rdata is registered from rf[host_addr] and reflects writes committed on prior edges.
- Counter saturation: op_count stays at 16'hFFFF once reached.
- in_valid deasserted while in_ready = 1: no state change.
- Payload is sampled only on the accept edge; changes after that are ignored.

Test Plan:
- Host writes r1 = 10, r2 = -15; op ADD (19) rd = 3, ra = 1, rb = 2 with a real ALU.
  - Expect alu_a = 10 and alu_b = 0xFFFF_FFFF_FFFF_FFF1 one cycle after accept.
  - Expect res_valid two cycles after accept, res_data = 0xFFFF_FFFF_FFFF_FFFB, host readback of r3 equal, op_count = 1.
- in_valid held high with 3 ops (XOR, AND, SUB) queued from the bench.
  - Expect in_ready pattern 1,0,0,1,0,0,1 and exactly 3 res_valid pulses spaced 3 cycles apart.
- Op with cmd 30, rd = 4.
  - Expect res_valid with res_err = 1 one cycle after accept, alu_* unchanged from the previous op, r4 unchanged.
- ADDM (18) with opm = 7'b1111110 (-2), ra = 1 (= 5), rd = 0.
  - Expect res_data = 3, r0 still reads 0.
- On the ISSUE→DONE edge, host_we to r5 = 0xAA while the op writes rd = 5 with result 0x55.
  - Expect r5 = 0x55.
- Accept an op, assert rst during ISSUE.
  - Expect no res_valid, all rf = 0, in_ready = 1 after deassert, op_count = 0.
